// File: rtl/sram_port0_arbiter.sv
// sram_port0_arbiter: shares port 0 of the 32x512 OpenRAM macro between the
// Wishbone slave window and the core data-RAM requester. A four-state FSM
// sequences each access (IDLE -> CMD -> [WAIT] -> ACK). All SRAM control
// and acknowledge state is registered, and ties are broken round-robin.
module sram_port0_arbiter #(
  parameter logic [31:0] WB_BASE = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        rst_n,
  // Wishbone classic slave
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  // core data-RAM requester
  input  logic        core_req,
  input  logic        core_we,
  input  logic [8:0]  core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic        core_ack,
  output logic [31:0] core_rdata,
  // SRAM port 0
  output logic        ram_csb,
  output logic        ram_web,
  output logic [8:0]  ram_addr,
  output logic [31:0] ram_din,
  output logic [3:0]  ram_wmask,
  input  logic [31:0] ram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_WAIT, S_ACK} state_t;

  state_t      state_q;
  logic        last_grant_q;   // 1: core was granted last, 0: Wishbone
  logic        grant_core_q;   // side owning the in-flight access
  logic        we_q;
  logic        ram_csb_q, ram_web_q;
  logic [8:0]  ram_addr_q;
  logic [31:0] ram_din_q;
  logic [3:0]  ram_wmask_q;
  logic [31:0] rdata_q;
  logic        wb_ack_q, core_ack_q, busy_q;

  logic        wb_hit, wb_req, any_req, grant_core_d;

  // Byte-offset bits never select anything inside a word.
  logic        unused_adr;
  assign unused_adr = ^wbs_adr_i[1:0];

  // Request decode and round-robin tie-break (tie goes opposite the last grant).
  always_comb begin
    wb_hit       = (wbs_adr_i[31:11] == WB_BASE[31:11]);
    wb_req       = wbs_cyc_i & wbs_stb_i & wb_hit;
    any_req      = wb_req | core_req;
    grant_core_d = core_req & (~wb_req | ~last_grant_q);
  end

  // Access sequencer: grant, one-cycle chip select, read capture, ack pulse.
  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b0;
      grant_core_q <= 1'b0;
      we_q         <= 1'b0;
      ram_csb_q    <= 1'b1;
      ram_web_q    <= 1'b1;
      ram_addr_q   <= '0;
      ram_din_q    <= '0;
      ram_wmask_q  <= '0;
      rdata_q      <= '0;
      wb_ack_q     <= 1'b0;
      core_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      wb_ack_q   <= 1'b0;
      core_ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            state_q      <= S_CMD;
            busy_q       <= 1'b1;
            ram_csb_q    <= 1'b0;
            grant_core_q <= grant_core_d;
            last_grant_q <= grant_core_d;
            if (grant_core_d) begin
              we_q        <= core_we;
              ram_web_q   <= ~core_we;
              ram_addr_q  <= core_addr;
              ram_din_q   <= core_wdata;
              ram_wmask_q <= core_wmask;
            end else begin
              we_q        <= wbs_we_i;
              ram_web_q   <= ~wbs_we_i;
              ram_addr_q  <= wbs_adr_i[10:2];
              ram_din_q   <= wbs_dat_i;
              ram_wmask_q <= wbs_sel_i;
            end
          end
        end
        S_CMD: begin
          // SRAM samples at the end of this cycle; release it right after.
          ram_csb_q <= 1'b1;
          ram_web_q <= 1'b1;
          if (we_q) begin
            state_q    <= S_ACK;
            wb_ack_q   <= ~grant_core_q;
            core_ack_q <= grant_core_q;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          rdata_q    <= ram_dout;
          state_q    <= S_ACK;
          wb_ack_q   <= ~grant_core_q;
          core_ack_q <= grant_core_q;
        end
        S_ACK: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          busy_q    <= 1'b0;
          ram_csb_q <= 1'b1;
          ram_web_q <= 1'b1;
        end
      endcase
    end
  end

  // An aborted Wishbone cycle still completes in the SRAM but is not acked.
  assign wbs_ack_o  = wb_ack_q & wbs_cyc_i & wbs_stb_i;
  assign wbs_dat_o  = rdata_q;
  assign core_ack   = core_ack_q;
  assign core_rdata = rdata_q;
  assign ram_csb    = ram_csb_q;
  assign ram_web    = ram_web_q;
  assign ram_addr   = ram_addr_q;
  assign ram_din    = ram_din_q;
  assign ram_wmask  = ram_wmask_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_sram_port0_arbiter.sv
// Bench for sram_port0_arbiter: SRAM port-0 model, directed vector table,
// hand-written corner sequences and a randomized two-master run checked
// against a shadow memory and a fairness latency bound.
module tb_sram_port0_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [31:0] wbs_adr_i, wbs_dat_i;
  logic [3:0]  wbs_sel_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        core_req, core_we;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wmask;
  logic        core_ack;
  logic [31:0] core_rdata;
  logic        ram_csb, ram_web;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic [3:0]  ram_wmask;
  logic [31:0] ram_dout;
  logic        busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_port0_arbiter dut (
    .wb_clk_i(clk), .rst_n(rst_n),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_wmask(core_wmask),
    .core_ack(core_ack), .core_rdata(core_rdata),
    .ram_csb(ram_csb), .ram_web(ram_web), .ram_addr(ram_addr),
    .ram_din(ram_din), .ram_wmask(ram_wmask), .ram_dout(ram_dout),
    .busy(busy)
  );

  // OpenRAM port-0 model: samples on the clock edge while csb is low.
  logic [31:0] mem [512] = '{default: 32'h0};
  always @(posedge clk) begin
    if (!ram_csb) begin
      if (!ram_web) begin
        for (int b = 0; b < 4; b++)
          if (ram_wmask[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
    end
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Chip select must be a single-cycle pulse and only while busy.
  logic prev_csb_low = 1'b0;
  always @(negedge clk) begin
    if (!ram_csb) begin
      chk("csb_single_cycle", {31'b0, prev_csb_low}, 32'd0);
      chk("csb_only_when_busy", {31'b0, busy}, 32'd1);
    end
    prev_csb_low = !ram_csb;
  end

  typedef struct {
    bit          core;
    bit          we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  msk;
    bit          hit;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic wb_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0;
    wbs_adr_i = '0; wbs_dat_i = '0; wbs_sel_i = '0;
  endtask

  task automatic core_idle();
    core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0; core_wmask = '0;
  endtask

  task automatic drive(input vec_t v);
    if (v.core) begin
      core_req = 1; core_we = v.we; core_addr = v.adr[8:0];
      core_wdata = v.dat; core_wmask = v.msk;
    end else begin
      wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = v.we;
      wbs_adr_i = v.adr; wbs_dat_i = v.dat; wbs_sel_i = v.msk;
    end
  endtask

  task automatic reset_and_check();
    rst_n = 0; wb_idle(); core_idle();
    @(negedge clk);
    chk("rst_csb", {31'b0, ram_csb}, 32'd1);
    chk("rst_web", {31'b0, ram_web}, 32'd1);
    chk("rst_addr", {23'b0, ram_addr}, 32'd0);
    chk("rst_din", ram_din, 32'd0);
    chk("rst_wmask", {28'b0, ram_wmask}, 32'd0);
    chk("rst_wb_dat", wbs_dat_o, 32'd0);
    chk("rst_core_rdata", core_rdata, 32'd0);
    chk("rst_acks", {30'b0, wbs_ack_o, core_ack}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  // One isolated transaction starting at a negedge with the FSM idle.
  task automatic xact(input vec_t v, output int lat, output logic [31:0] rd,
                      output int csb_cnt, output logic [8:0] c_addr,
                      output logic c_web, output logic [3:0] c_msk,
                      output logic [31:0] c_din, output bit other_ack,
                      output bit busy_seen);
    lat = 0; rd = '0; csb_cnt = 0; c_addr = '0; c_web = 1; c_msk = '0;
    c_din = '0; other_ack = 0; busy_seen = 0;
    drive(v);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (!ram_csb) begin
        csb_cnt++; c_addr = ram_addr; c_web = ram_web; c_msk = ram_wmask; c_din = ram_din;
      end
      if (busy) busy_seen = 1;
      if (v.core ? wbs_ack_o : core_ack) other_ack = 1;
      if (v.core ? core_ack : wbs_ack_o) begin
        lat = c; rd = v.core ? core_rdata : wbs_dat_o;
        break;
      end
    end
    if (v.core) core_idle(); else wb_idle();
    @(negedge clk);
  endtask

  // Both sides raised on the same edge; records the cycle each ack appears.
  task automatic pair(input vec_t wv, input vec_t cv, output int wb_c, output int core_c,
                      output logic [31:0] wb_rd, output logic [31:0] core_rd);
    wb_c = 0; core_c = 0; wb_rd = '0; core_rd = '0;
    drive(wv); drive(cv);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (core_ack && core_c == 0) begin core_c = c; core_rd = core_rdata; core_idle(); end
      if (wbs_ack_o && wb_c == 0) begin wb_c = c; wb_rd = wbs_dat_o; wb_idle(); end
      if (wb_c != 0 && core_c != 0) break;
    end
    wb_idle(); core_idle();
    @(negedge clk);
  endtask

  // Random master: own address half, shadow-memory data check, wait bound.
  logic [31:0] shadow [512];

  task automatic rand_master(input bit is_core, input int n);
    vec_t v;
    int lat;
    logic [31:0] rd;
    logic [8:0] w;
    for (int t = 0; t < n; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      w = {is_core, 4'b0, 4'($urandom_range(0, 15))};
      v.core = is_core; v.we = 1'($urandom_range(0, 1)); v.dat = $urandom;
      v.msk = 4'($urandom_range(0, 15)); v.hit = 1; v.exp_rd = '0;
      v.adr = is_core ? {23'b0, w} : {21'h30000 >> 1, w, 2'b00};
      v.adr = is_core ? {23'b0, w} : (32'h3000_0000 | {21'b0, w, 2'b00});
      drive(v);
      lat = 0; rd = '0;
      for (int c = 1; c <= 30; c++) begin
        @(negedge clk);
        if (is_core ? core_ack : wbs_ack_o) begin
          lat = c; rd = is_core ? core_rdata : wbs_dat_o;
          break;
        end
      end
      if (is_core) core_idle(); else wb_idle();
      chk(is_core ? "core_rand_acked" : "wb_rand_acked", {31'b0, lat != 0}, 32'd1);
      chk(is_core ? "core_rand_wait_bound" : "wb_rand_wait_bound", {31'b0, lat <= 8}, 32'd1);
      if (v.we) begin
        for (int b = 0; b < 4; b++)
          if (v.msk[b]) shadow[w][8*b +: 8] = v.dat[8*b +: 8];
      end else begin
        chk(is_core ? "core_rand_rdata" : "wb_rand_rdata", rd, shadow[w]);
      end
    end
  endtask

  vec_t tbl [14];

  initial begin
    int lat, csb_cnt, wb_c, core_c, acks;
    logic [31:0] rd, c_din, wb_rd, core_rd;
    logic [8:0] c_addr;
    logic c_web;
    logic [3:0] c_msk;
    bit other_ack, busy_seen;
    vec_t wv, cv;

    //            core we  adr            dat            msk   hit exp_rd
    tbl[0]  = '{0, 1, 32'h3000_0010, 32'hDEADBEEF, 4'hF, 1, 32'h0};
    tbl[1]  = '{0, 0, 32'h3000_0010, 32'h0,        4'hF, 1, 32'hDEADBEEF};
    tbl[2]  = '{1, 1, 32'd7,         32'h12345678, 4'h3, 1, 32'h0};
    tbl[3]  = '{1, 0, 32'd7,         32'h0,        4'h0, 1, 32'h0000_5678};
    tbl[4]  = '{0, 0, 32'h3000_001C, 32'h0,        4'hF, 1, 32'h0000_5678};
    tbl[5]  = '{0, 1, 32'h3000_0800, 32'h11111111, 4'hF, 0, 32'h0};
    tbl[6]  = '{0, 0, 32'h3000_0000, 32'h0,        4'hF, 1, 32'h0};
    tbl[7]  = '{0, 1, 32'h2FFF_FFFC, 32'h22222222, 4'hF, 0, 32'h0};
    tbl[8]  = '{1, 0, 32'd511,       32'h0,        4'h0, 1, 32'h0};
    tbl[9]  = '{0, 1, 32'h3000_07FC, 32'hAABBCCDD, 4'h5, 1, 32'h0};
    tbl[10] = '{1, 0, 32'd511,       32'h0,        4'h0, 1, 32'h00BB_00DD};
    tbl[11] = '{0, 1, 32'h3000_0014, 32'hC0FFEE05, 4'hF, 1, 32'h0};
    tbl[12] = '{1, 1, 32'd6,         32'h0BADF00D, 4'hC, 1, 32'h0};
    tbl[13] = '{0, 0, 32'h3000_0018, 32'h0,        4'hF, 1, 32'h0BAD_0000};

    reset_and_check();

    foreach (tbl[i]) begin
      xact(tbl[i], lat, rd, csb_cnt, c_addr, c_web, c_msk, c_din, other_ack, busy_seen);
      chk($sformatf("v%0d_ack_latency", i), lat, tbl[i].hit ? (tbl[i].we ? 2 : 3) : 0);
      chk($sformatf("v%0d_csb_cycles", i), csb_cnt, {31'b0, tbl[i].hit});
      chk($sformatf("v%0d_other_ack", i), {31'b0, other_ack}, 32'd0);
      if (tbl[i].hit) begin
        chk($sformatf("v%0d_ram_addr", i), {23'b0, c_addr},
            tbl[i].core ? {23'b0, tbl[i].adr[8:0]} : {23'b0, tbl[i].adr[10:2]});
        chk($sformatf("v%0d_ram_web", i), {31'b0, c_web}, {31'b0, ~tbl[i].we});
        if (tbl[i].we) begin
          chk($sformatf("v%0d_ram_wmask", i), {28'b0, c_msk}, {28'b0, tbl[i].msk});
          chk($sformatf("v%0d_ram_din", i), c_din, tbl[i].dat);
        end else begin
          chk($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rd);
        end
      end else begin
        chk($sformatf("v%0d_busy_stays_low", i), {31'b0, busy_seen}, 32'd0);
      end
    end

    // First tie after reset goes to the core, then the held WB request.
    reset_and_check();
    wv = '{0, 1, 32'h3000_0000, 32'h0F0F0F0F, 4'hF, 1, 32'h0};
    cv = '{1, 0, 32'd5,         32'h0,        4'h0, 1, 32'h0};
    pair(wv, cv, wb_c, core_c, wb_rd, core_rd);
    chk("tie1_core_ack_cycle", core_c, 32'd3);
    chk("tie1_wb_ack_cycle", wb_c, 32'd6);
    chk("tie1_core_rdata", core_rd, 32'hC0FFEE05);

    // A lone core access leaves last grant on the core, so the next tie goes to WB.
    cv = '{1, 0, 32'd0, 32'h0, 4'h0, 1, 32'h0};
    xact(cv, lat, rd, csb_cnt, c_addr, c_web, c_msk, c_din, other_ack, busy_seen);
    chk("lone_core_latency", lat, 32'd3);
    chk("lone_core_rdata", rd, 32'h0F0F0F0F);
    wv = '{0, 0, 32'h3000_0014, 32'h0,        4'hF, 1, 32'h0};
    cv = '{1, 1, 32'd8,         32'h87654321, 4'hF, 1, 32'h0};
    pair(wv, cv, wb_c, core_c, wb_rd, core_rd);
    chk("tie2_wb_ack_cycle", wb_c, 32'd3);
    chk("tie2_core_ack_cycle", core_c, 32'd6);
    chk("tie2_wb_rdata", wb_rd, 32'hC0FFEE05);

    // WB read aborted during WAIT: no ack, data still captured.
    wv = '{0, 0, 32'h3000_0018, 32'h0, 4'hF, 1, 32'h0};
    drive(wv);
    acks = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (wbs_ack_o || core_ack) acks++;
      if (c == 2) wb_idle();
      if (c == 3) begin
        chk("abort_rdata_wb", wbs_dat_o, 32'h0BAD_0000);
        chk("abort_rdata_core", core_rdata, 32'h0BAD_0000);
        chk("abort_busy_in_ack", {31'b0, busy}, 32'd1);
      end
      if (c == 4) chk("abort_busy_low", {31'b0, busy}, 32'd0);
    end
    chk("abort_no_ack", acks, 32'd0);

    // Reset during WAIT of a core read, then the held request completes.
    cv = '{1, 0, 32'd7, 32'h0, 4'h0, 1, 32'h0};
    drive(cv);
    @(negedge clk);
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("midrst_csb", {31'b0, ram_csb}, 32'd1);
    chk("midrst_core_ack", {31'b0, core_ack}, 32'd0);
    chk("midrst_rdata", core_rdata, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    lat = 0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (core_ack) begin lat = c; rd = core_rdata; break; end
    end
    core_idle();
    chk("postrst_latency", lat, 32'd3);
    chk("postrst_rdata", rd, 32'h0000_5678);
    @(negedge clk);

    // Randomized concurrent traffic against the shadow memory.
    for (int i = 0; i < 512; i++) shadow[i] = mem[i];
    fork
      rand_master(1'b0, 40);
      rand_master(1'b1, 40);
    join

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
